// File: rtl/morph_erode3x3.sv
// morph_erode3x3
//   Streaming 3x3 binary erosion of the white foreground of the Sobel edge
//   map. An output pixel is WHITE only when all nine pixels of its 3x3
//   neighbourhood are foreground (non-zero). This removes isolated specks and
//   thins edges. The block follows the raster pixel_x/pixel_y timing and only
//   acts inside the fixed picture window.
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   pixel_x/y    current raster column/row (screen coordinates)
//   rgb_data     edge-map pixel at (pixel_x, pixel_y); non-zero = foreground
//   k_erode_out  eroded pixel, WHITE or 0, registered
//   out_valid    k_erode_out is valid for (out_x, out_y)
//   out_x/out_y  screen coordinates of the output pixel (window centre)
//
// States
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | after reset; waiting for a frame start, never outputs WHITE
//   FILL   | rows 0..1 of the frame; line buffers are being (re)filled
//   RUN    | rows >= 2; both line buffers hold this frame's earlier rows

module morph_erode3x3 #(
    parameter logic [10:0] PIC_X_START = 11'd200,
    parameter logic [10:0] PIC_Y_START = 11'd100,
    parameter logic [10:0] PIC_WIDTH   = 11'd200,
    parameter logic [10:0] PIC_HEIGHT  = 11'd200,
    parameter logic [23:0] WHITE       = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic [23:0] rgb_data,
    output logic [23:0] k_erode_out,
    output logic        out_valid,
    output logic [10:0] out_x,
    output logic [10:0] out_y
);

    localparam int AW = (PIC_WIDTH > 11'd1) ? $clog2(PIC_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic          in_win;
    logic [10:0]   c;
    logic [10:0]   r;
    logic [AW-1:0] c_idx;
    logic          fg;
    logic          frame_start;

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic lb0 [0:PIC_WIDTH-1];
    logic lb1 [0:PIC_WIDTH-1];
    logic lb0_rd;
    logic lb1_rd;

    // win[row][col]: row 0 = two rows back, row 2 = current row;
    // col 0 = oldest column, col 2 = newest column.
    logic [2:0][2:0] win;
    logic [2:0][2:0] win_next;
    logic [2:0][2:0] win_base;
    logic [2:0]      new_col;
    logic            all_ones;

    assign in_win = (pixel_x >= PIC_X_START) && (pixel_x < PIC_X_START + PIC_WIDTH) &&
                    (pixel_y >= PIC_Y_START) && (pixel_y < PIC_Y_START + PIC_HEIGHT);

    // c and r are only meaningful while in_win is high.
    assign c     = pixel_x - PIC_X_START;
    assign r     = pixel_y - PIC_Y_START;
    assign c_idx = c[AW-1:0];
    assign fg    = (rgb_data != 24'd0);

    assign frame_start = in_win && (c == 11'd0) && (r == 11'd0);

    // Reads happen before the write of this cycle takes effect.
    assign lb0_rd = lb0[c_idx];
    assign lb1_rd = lb1[c_idx];

    assign new_col = {fg, lb0_rd, lb1_rd};

    always_comb begin
        win_base = win;
        win_next = win;
        if (in_win) begin
            // Clear at each row start so the previous row's columns never
            // leak into the first windows of a new row.
            if (c == 11'd0) begin
                win_base = '0;
            end
            for (int row = 0; row < 3; row++) begin
                win_next[row] = {new_col[row], win_base[row][2:1]};
            end
        end
    end

    assign all_ones = &win_next;

    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = S_FILL;
        end else if (in_win && (c == 11'd0) && (r == 11'd2) && (state == S_FILL)) begin
            state_next = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Line buffers carry no reset: FILL rewrites both rows before RUN reads them.
    always_ff @(posedge clk) begin
        if (in_win) begin
            lb1[c_idx] <= lb0_rd;
            lb0[c_idx] <= fg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win         <= '0;
            out_valid   <= 1'b0;
            k_erode_out <= 24'd0;
            out_x       <= 11'd0;
            out_y       <= 11'd0;
        end else begin
            win <= win_next;
            if (in_win) begin
                out_valid <= 1'b1;
                out_x     <= pixel_x - 11'd1;
                out_y     <= pixel_y - 11'd1;
                // c >= 2 guarantees all three columns belong to this row;
                // RUN guarantees the two upper rows belong to this frame.
                if ((state == S_RUN) && (c >= 11'd2) && all_ones) begin
                    k_erode_out <= WHITE;
                end else begin
                    k_erode_out <= 24'd0;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morph_erode3x3.sv
module tb_morph_erode3x3;

    localparam logic [10:0] XS = 11'd4;
    localparam logic [10:0] YS = 11'd2;
    localparam int W = 8;
    localparam int H = 6;
    localparam logic [23:0] WH = 24'hFFFFFF;

    logic        clk;
    logic        rst;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic [23:0] rgb_data;
    logic [23:0] k_erode_out;
    logic        out_valid;
    logic [10:0] out_x;
    logic [10:0] out_y;

    int n_cmp;
    int n_err;

    bit img [0:H-1][0:W-1];

    // Reference state: expected registered outputs and whether a frame start
    // has been seen since the last reset.
    logic [23:0] exp_k;
    logic        exp_valid;
    logic [10:0] exp_x;
    logic [10:0] exp_y;
    bit          armed;
    int          cur_x;
    int          cur_y;

    morph_erode3x3 #(
        .PIC_X_START(XS),
        .PIC_Y_START(YS),
        .PIC_WIDTH  (11'd8),
        .PIC_HEIGHT (11'd6),
        .WHITE      (WH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .rgb_data   (rgb_data),
        .k_erode_out(k_erode_out),
        .out_valid  (out_valid),
        .out_x      (out_x),
        .out_y      (out_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] expv);
        n_cmp++;
        assert (got === expv)
        else begin
            n_err++;
            $error("FAIL %s at x=%0d y=%0d: observed %h expected %h", tag, cur_x, cur_y, got, expv);
        end
    endtask

    // mode 0: all white; 1: all white but (c5,r3) black;
    // 2: all black but (c3,r2) white; 3: white only for c<5
    task automatic load_img(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0: img[r][c] = 1'b1;
                    1: img[r][c] = !(c == 5 && r == 3);
                    2: img[r][c] = (c == 3 && r == 2);
                    default: img[r][c] = (c < 5);
                endcase
            end
        end
    endtask

    task automatic step(input int x, input int y, input logic [23:0] d, input logic rv);
        bit win;
        bit ok9;
        int c;
        int r;
        pixel_x  = 11'(x);
        pixel_y  = 11'(y);
        rgb_data = d;
        rst      = rv;
        cur_x    = x;
        cur_y    = y;
        c   = x - int'(XS);
        r   = y - int'(YS);
        win = (c >= 0) && (c < W) && (r >= 0) && (r < H);
        if (rv) begin
            exp_valid = 1'b0;
            exp_k     = 24'd0;
            exp_x     = 11'd0;
            exp_y     = 11'd0;
            armed     = 1'b0;
        end else if (win) begin
            if (c == 0 && r == 0) armed = 1'b1;
            ok9 = (c >= 2) && (r >= 2);
            if (ok9) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (!img[r-2+i][c-2+j]) ok9 = 1'b0;
            end
            exp_valid = 1'b1;
            exp_x     = 11'(x - 1);
            exp_y     = 11'(y - 1);
            exp_k     = (armed && ok9) ? WH : 24'd0;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("out_valid", {23'd0, out_valid}, {23'd0, exp_valid});
        check("k_erode_out", k_erode_out, exp_k);
        if (rv || win) begin
            check("out_x", {13'd0, out_x}, {13'd0, exp_x});
            check("out_y", {13'd0, out_y}, {13'd0, exp_y});
        end
    endtask

    // Scans one row above the window to the row below it, and two columns
    // either side, feeding WHITE outside the window to prove it is ignored.
    task automatic run_frame(input int rst_r, input int rst_c);
        int c;
        int r;
        logic [23:0] d;
        logic rv;
        for (int y = int'(YS) - 1; y <= int'(YS) + H; y++) begin
            for (int x = int'(XS) - 2; x < int'(XS) + W + 2; x++) begin
                c  = x - int'(XS);
                r  = y - int'(YS);
                d  = 24'hFFFFFF;
                rv = 1'b0;
                if (c >= 0 && c < W && r >= 0 && r < H) begin
                    d  = img[r][c] ? (24'h1 << ((c + r) % 24)) : 24'h0;
                    rv = (r == rst_r) && (c == rst_c);
                end
                step(x, y, d, rv);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_k     = 24'd0;
        exp_valid = 1'b0;
        exp_x     = 11'd0;
        exp_y     = 11'd0;
        armed     = 1'b0;
        rst       = 1'b1;
        pixel_x   = 11'd0;
        pixel_y   = 11'd0;
        rgb_data  = 24'd0;
        load_img(0);

        step(0, 0, 24'd0, 1'b1);
        step(0, 0, 24'hFFFFFF, 1'b1);
        // out-of-window after reset: nothing valid
        step(3, 4, 24'hFFFFFF, 1'b0);
        step(6, 8, 24'hFFFFFF, 1'b0);

        load_img(0);
        run_frame(-1, -1);
        load_img(1);
        run_frame(-1, -1);
        load_img(2);
        run_frame(-1, -1);
        load_img(0);
        run_frame(3, 4);
        load_img(0);
        run_frame(-1, -1);
        load_img(3);
        run_frame(-1, -1);
        load_img(2);
        run_frame(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
